// File: rtl/store_lane_packer.sv
// ----------------------------------------------------------------------------
// store_lane_packer
//   Store-side data path between the MEM-stage controller and data RAM.
//   Narrows a 32-bit register value to a byte, halfword or word store.
//   Places the bytes on their little-endian lanes with matching byte enables.
//   Runs the req/ack write handshake with data memory.
//
// Ports
//   CLK        in   rising-edge system clock
//   Reset      in   synchronous, active-high; forces IDLE and clears outputs
//   start      in   1-cycle launch pulse, only honoured in IDLE
//   StoreSize  in   00 word, 01 half, 10 byte, 11 reserved (behaves as word)
//   addr       in   byte address of the store
//   wdata_in   in   register data (byte in [7:0], half in [15:0])
//   mem_addr   out  word-aligned address of the current beat
//   mem_wdata  out  lane-aligned write data, unenabled lanes are zero
//   mem_be     out  byte enables, bit k covers bits [8k+7:8k]
//   mem_we     out  write request, held until mem_ack
//   mem_ack    in   memory accepted the current beat this cycle
//   busy       out  high from the cycle after start through the done cycle
//   done       out  1-cycle completion pulse
//   misalign   out  qualifies done: store was aborted, nothing written
//
// Build option
//   STORE_SPLIT_EN  when defined, misaligned halfword/word stores complete
//                   (one or two beats) instead of faulting.
// ----------------------------------------------------------------------------
module store_lane_packer #(
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              start,
   input  logic [1:0]        StoreSize,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   output logic              mem_we,
   input  logic              mem_ack,
   output logic              busy,
   output logic              done,
   output logic              misalign
);

`ifdef STORE_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WR1   = 3'd1,
      S_WR2   = 3'd2,
      S_DONE  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   state_t state_q, state_d;

   // Second beat is captured at launch so later input changes cannot leak in.
   logic [ADDR_W-1:0] b2_addr_q, b2_addr_d;
   logic [31:0]       b2_data_q, b2_data_d;
   logic [3:0]        b2_be_q, b2_be_d;
   logic              two_beat_q, two_beat_d;

   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_be_q, mem_be_d;
   logic              mem_we_q, mem_we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              misalign_q, misalign_d;

   // Lane placement of the incoming request
   logic [1:0]        lane_ofs;
   logic [31:0]       size_data;
   logic [3:0]        size_be;
   logic              aligned;
   logic [63:0]       wide_data;
   logic [7:0]        wide_be;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] next_addr;
   logic              fault;

   always_comb begin
      lane_ofs = addr[1:0];
      case (StoreSize)
         2'b10: begin
            size_data = {24'd0, wdata_in[7:0]};
            size_be   = 4'b0001;
            aligned   = 1'b1;
         end
         2'b01: begin
            size_data = {16'd0, wdata_in[15:0]};
            size_be   = 4'b0011;
            aligned   = ~lane_ofs[0];
         end
         default: begin
            size_data = wdata_in;
            size_be   = 4'b1111;
            aligned   = (lane_ofs == 2'b00);
         end
      endcase
      // Shifting into a double-width window: the low half is beat 1 and
      // whatever spills over the word boundary is beat 2.
      wide_data = {32'd0, size_data} << {lane_ofs, 3'b000};
      wide_be   = {4'd0, size_be} << lane_ofs;
      base_addr = {addr[ADDR_W-1:2], 2'b00};
      next_addr = base_addr + ADDR_W'(4);   // wraps to 0 past the top
      fault     = SPLIT_EN ? 1'b0 : ~aligned;
   end

   always_comb begin
      state_d     = state_q;
      b2_addr_d   = b2_addr_q;
      b2_data_d   = b2_data_q;
      b2_be_d     = b2_be_q;
      two_beat_d  = two_beat_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_be_d    = mem_be_q;
      mem_we_d    = mem_we_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      misalign_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               busy_d     = 1'b1;
               b2_addr_d  = next_addr;
               b2_data_d  = wide_data[63:32];
               b2_be_d    = wide_be[7:4];
               two_beat_d = |wide_be[7:4];
               if (fault) begin
                  state_d    = S_FAULT;
                  done_d     = 1'b1;
                  misalign_d = 1'b1;
               end else begin
                  state_d     = S_WR1;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = base_addr;
                  mem_wdata_d = wide_data[31:0];
                  mem_be_d    = wide_be[3:0];
               end
            end
         end
         S_WR1: begin
            if (mem_ack) begin
               if (two_beat_q) begin
                  state_d     = S_WR2;
                  mem_addr_d  = b2_addr_q;
                  mem_wdata_d = b2_data_q;
                  mem_be_d    = b2_be_q;
               end else begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  mem_we_d    = 1'b0;
                  mem_addr_d  = '0;
                  mem_wdata_d = '0;
                  mem_be_d    = '0;
               end
            end
         end
         S_WR2: begin
            if (mem_ack) begin
               state_d     = S_DONE;
               done_d      = 1'b1;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               mem_be_d    = '0;
            end
         end
         S_DONE, S_FAULT: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         b2_addr_q   <= '0;
         b2_data_q   <= '0;
         b2_be_q     <= '0;
         two_beat_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         mem_we_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         b2_addr_q   <= b2_addr_d;
         b2_data_q   <= b2_data_d;
         b2_be_q     <= b2_be_d;
         two_beat_q  <= two_beat_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_be_q    <= mem_be_d;
         mem_we_q    <= mem_we_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         misalign_q  <= misalign_d;
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign mem_we    = mem_we_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign misalign  = misalign_q;

endmodule
